accum_zone_wr_arbiter: RTL and testbench
========================================

ACCUM_ZONE_WR_ARBITER -- requirements
Module: accum_zone_wr_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 2, number of write requesters sharing one zone (index 0 = direct port, 1.. = routed ports).
REQ-002 Parameter NUM_BANKS, default 4, banks per write beat.
REQ-003 Parameter ADDR_WIDTH, default 9, write address width.
REQ-004 Parameter DATA_WIDTH, default 64, per-bank data width.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 req_wr_valid  input  NUM_REQ  per-requester command valid.
REQ-008 req_wr_ready  output  NUM_REQ  per-requester command ready.
REQ-009 req_wr_addr  input  NUM_REQ*ADDR_WIDTH  per-requester address, requester i at slice i.
REQ-010 req_wr_mask  input  NUM_REQ*NUM_BANKS  per-requester bank mask.
REQ-011 req_accum_en  input  NUM_REQ  per-requester accumulate enable.
REQ-012 req_wvalid  input  NUM_REQ  per-requester data valid.
REQ-013 req_wready  output  NUM_REQ  per-requester data ready.
REQ-014 req_wdata  input  NUM_REQ*NUM_BANKS*DATA_WIDTH  per-requester write beat.
REQ-015 zone_wr_valid / zone_wr_addr / zone_wr_mask / zone_accum_en  output  1/ADDR_WIDTH/NUM_BANKS/1  command to zone.
REQ-016 zone_wr_ready  input  1  zone command ready.
REQ-017 zone_wvalid / zone_wdata  output  1/NUM_BANKS*DATA_WIDTH  data to zone.
REQ-018 zone_wready  input  1  zone data ready.
REQ-019 grant_id  output  $clog2(NUM_REQ) (min 1)  index of locked requester; busy  output  1  high in LOCK.

Function
REQ-020 FSM states IDLE and LOCK; IDLE: all ready outputs 0, zone_wr_valid=0, zone_wvalid=0.
REQ-021 IDLE with any req_wr_valid set: winner registered into grant_id, transition to LOCK next edge (one-cycle arbitration latency); no valid: stay IDLE.
REQ-022 Winner chosen on req_wr_valid only; req_wvalid does not influence arbitration.
REQ-023 LOCK: zone_wr_addr/mask/accum_en and zone_wdata muxed combinationally from requester grant_id.
REQ-024 LOCK: zone_wr_valid = req_wr_valid[grant_id] & ~cmd_done; req_wr_ready[grant_id] = zone_wr_ready & ~cmd_done; cmd_done set on that handshake.
REQ-025 LOCK: zone_wvalid = req_wvalid[grant_id] & ~data_done; req_wready[grant_id] = zone_wready & ~data_done; data_done set on that handshake.
REQ-026 Command and data handshakes independent; either order or same cycle accepted.
REQ-027 When both handshakes complete (flags or current-cycle handshakes): clear cmd_done/data_done, return to IDLE next edge.
REQ-028 Non-granted requesters: ready outputs 0 at all times.
REQ-029 Requester deasserting valid mid-LOCK is not aborted; arbiter holds LOCK until both handshakes complete.
REQ-030 Back-to-back throughput: at most one transaction per two cycles (LOCK + IDLE).
REQ-031 No combinational path from req_wr_valid to any ready output.

Reset
REQ-032 rst high at an edge: state=IDLE, grant_id=0, cmd_done=data_done=0, RR pointer=0, busy=0; all valid/ready outputs 0 while rst high.
REQ-033 rst mid-LOCK discards in-flight transaction; no partial handshake issued after rst asserted.

Configuration
REQ-034 Macro ACCUM_ZONE_ARB_RR_EN defined: round-robin; search starts at pointer, pointer = grant_id+1 mod NUM_REQ on LOCK->IDLE.
REQ-035 Macro ACCUM_ZONE_ARB_RR_EN undefined: fixed priority, lowest index wins; pointer logic absent.

Verification
REQ-036 Single requester 0, addr 0x010, mask 0xF, zone readies high -> busy 1 cycle after valid, cmd and data handshake same cycle, IDLE next.
REQ-037 Requester 1, zone_wready held low 3 cycles, zone_wr_ready high -> cmd_done set first, wready to requester rises only when zone_wready rises, one zone beat total.
REQ-038 Both requesters valid same cycle, RR_EN defined, 4 transactions each -> grants alternate 0,1,0,1...; undefined -> all 4 of requester 0 first.
REQ-039 Requester 0 addr 0x100 data 0xDDDD..., requester 1 addr 0x200 data 0xAAAA... -> zone sees each addr exactly once, paired with its own data.
REQ-040 rst asserted in LOCK with cmd_done=1 -> next cycle IDLE, all outputs 0, grant_id 0, no zone_wvalid.

Source files
------------

// File: rtl/accum_zone_wr_arbiter_if.sv
// Write-port bundle between the requesters and one accumulator zone.
// master = requester/zone side, slave = the arbiter.
interface accum_zone_wr_arbiter_if #(
    parameter int NUM_REQ    = 2,
    parameter int NUM_BANKS  = 4,
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 64
);
    logic [NUM_REQ-1:0]                      req_wr_valid;
    logic [NUM_REQ-1:0]                      req_wr_ready;
    logic [NUM_REQ*ADDR_WIDTH-1:0]           req_wr_addr;
    logic [NUM_REQ*NUM_BANKS-1:0]            req_wr_mask;
    logic [NUM_REQ-1:0]                      req_accum_en;
    logic [NUM_REQ-1:0]                      req_wvalid;
    logic [NUM_REQ-1:0]                      req_wready;
    logic [NUM_REQ*NUM_BANKS*DATA_WIDTH-1:0] req_wdata;

    logic                                    zone_wr_valid;
    logic                                    zone_wr_ready;
    logic [ADDR_WIDTH-1:0]                   zone_wr_addr;
    logic [NUM_BANKS-1:0]                    zone_wr_mask;
    logic                                    zone_accum_en;
    logic                                    zone_wvalid;
    logic                                    zone_wready;
    logic [NUM_BANKS*DATA_WIDTH-1:0]         zone_wdata;

    modport master (
        output req_wr_valid, req_wr_addr, req_wr_mask, req_accum_en,
               req_wvalid, req_wdata, zone_wr_ready, zone_wready,
        input  req_wr_ready, req_wready, zone_wr_valid, zone_wr_addr,
               zone_wr_mask, zone_accum_en, zone_wvalid, zone_wdata
    );

    modport slave (
        input  req_wr_valid, req_wr_addr, req_wr_mask, req_accum_en,
               req_wvalid, req_wdata, zone_wr_ready, zone_wready,
        output req_wr_ready, req_wready, zone_wr_valid, zone_wr_addr,
               zone_wr_mask, zone_accum_en, zone_wvalid, zone_wdata
    );
endinterface

// File: rtl/accum_zone_wr_arbiter.sv
// Locks one requester onto the zone write port until its command and data beats are both taken.
// Define ACCUM_ZONE_ARB_RR_EN for round-robin arbitration; otherwise lowest index wins.
module accum_zone_wr_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int NUM_BANKS  = 4,
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 64,
    localparam int GW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    accum_zone_wr_arbiter_if.slave  bus,
    output logic [GW-1:0]           grant_id,
    output logic                    busy
);
    localparam int BW = NUM_BANKS * DATA_WIDTH;

    // Handshake rule: a beat transfers on a rising edge where valid and ready are both high.
    typedef enum logic {IDLE, LOCK} state_t;

    state_t          state, state_n;
    logic [GW-1:0]   grant_n;
    logic            cmd_done, cmd_done_n;
    logic            data_done, data_done_n;
    logic            lock, cmd_hs, data_hs;
    logic            sel_wr_valid, sel_wvalid;
    logic [GW-1:0]   winner;
    logic            found;
    int              start, idx;
`ifdef ACCUM_ZONE_ARB_RR_EN
    logic [GW-1:0]   rr_ptr, rr_ptr_n;
`endif

    assign busy = (state == LOCK);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            grant_id  <= '0;
            cmd_done  <= 1'b0;
            data_done <= 1'b0;
`ifdef ACCUM_ZONE_ARB_RR_EN
            rr_ptr    <= '0;
`endif
        end else begin
            state     <= state_n;
            grant_id  <= grant_n;
            cmd_done  <= cmd_done_n;
            data_done <= data_done_n;
`ifdef ACCUM_ZONE_ARB_RR_EN
            rr_ptr    <= rr_ptr_n;
`endif
        end
    end

    always_comb begin
        state_n            = state;
        grant_n            = grant_id;
        cmd_done_n         = cmd_done;
        data_done_n        = data_done;
        sel_wr_valid       = 1'b0;
        sel_wvalid         = 1'b0;
        winner             = '0;
        found              = 1'b0;
        idx                = 0;
        bus.zone_wr_addr   = '0;
        bus.zone_wr_mask   = '0;
        bus.zone_accum_en  = 1'b0;
        bus.zone_wdata     = '0;
        bus.req_wr_ready   = '0;
        bus.req_wready     = '0;
`ifdef ACCUM_ZONE_ARB_RR_EN
        rr_ptr_n           = rr_ptr;
        start              = int'(rr_ptr);
`else
        start              = 0;
`endif
        // rst gates every valid/ready so an in-flight lock issues nothing once reset is seen
        lock = (state == LOCK) && !rst;

        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == GW'(i)) begin
                sel_wr_valid      = bus.req_wr_valid[i];
                sel_wvalid        = bus.req_wvalid[i];
                bus.zone_wr_addr  = bus.req_wr_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                bus.zone_wr_mask  = bus.req_wr_mask[i*NUM_BANKS +: NUM_BANKS];
                bus.zone_accum_en = bus.req_accum_en[i];
                bus.zone_wdata    = bus.req_wdata[i*BW +: BW];
                bus.req_wr_ready[i] = lock && bus.zone_wr_ready && !cmd_done;
                bus.req_wready[i]   = lock && bus.zone_wready && !data_done;
            end
        end

        bus.zone_wr_valid = lock && sel_wr_valid && !cmd_done;
        bus.zone_wvalid   = lock && sel_wvalid && !data_done;
        cmd_hs  = bus.zone_wr_valid && bus.zone_wr_ready;
        data_hs = bus.zone_wvalid && bus.zone_wready;

        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (start + k) % NUM_REQ;
            if (!found && bus.req_wr_valid[idx]) begin
                found  = 1'b1;
                winner = GW'(idx);
            end
        end

        case (state)
            IDLE: begin
                if (found) begin
                    state_n = LOCK;
                    grant_n = winner;
                end
            end
            LOCK: begin
                if ((cmd_done || cmd_hs) && (data_done || data_hs)) begin
                    state_n     = IDLE;
                    cmd_done_n  = 1'b0;
                    data_done_n = 1'b0;
`ifdef ACCUM_ZONE_ARB_RR_EN
                    rr_ptr_n = (grant_id == GW'(NUM_REQ-1)) ? '0 : grant_id + GW'(1);
`endif
                end else begin
                    if (cmd_hs)  cmd_done_n  = 1'b1;
                    if (data_hs) data_done_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_accum_zone_wr_arbiter.sv
// Bench for accum_zone_wr_arbiter: scenario tasks plus a zone-side scoreboard pairing
// each accepted command with its data beat against an expected queue.
module tb_accum_zone_wr_arbiter;
    localparam int NR = 2;
    localparam int NB = 4;
    localparam int AW = 10;
    localparam int DW = 64;
    localparam int BW = NB * DW;
    localparam int GW = 1;
    localparam int CW = AW + NB + 1;
    localparam int W  = CW + BW;

    logic clk;
    logic rst;
    logic [GW-1:0] grant_id;
    logic busy;

    int n_cmp  = 0;
    int n_fail = 0;
    int cmd_beats  = 0;
    int data_beats = 0;
    logic busy_q = 1'b0;

    logic [W-1:0]  exp_q[$];
    logic [CW-1:0] pend_cmd[$];
    logic [BW-1:0] pend_data[$];
    logic [GW-1:0] grant_log[$];

    accum_zone_wr_arbiter_if #(.NUM_REQ(NR), .NUM_BANKS(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    accum_zone_wr_arbiter #(.NUM_REQ(NR), .NUM_BANKS(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .grant_id (grant_id),
        .busy     (busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [BW-1:0] pattern(input int i, input int k);
        logic [BW-1:0] base;
        base = (i == 0) ? {(BW/4){4'hD}} : {(BW/4){4'hA}};
        return base ^ BW'(k);
    endfunction

    function automatic logic [AW-1:0] addr_of(input int i, input int k);
        return (i == 0) ? AW'(12'h100 + k) : AW'(12'h200 + k);
    endfunction

    // zone-side scoreboard
    always @(negedge clk) begin
        logic [CW-1:0] c;
        logic [BW-1:0] d;
        logic [W-1:0]  e;
        if (!rst) begin
            if (bus.zone_wr_valid && bus.zone_wr_ready) begin
                pend_cmd.push_back({bus.zone_wr_addr, bus.zone_wr_mask, bus.zone_accum_en});
                cmd_beats++;
            end
            if (bus.zone_wvalid && bus.zone_wready) begin
                pend_data.push_back(bus.zone_wdata);
                data_beats++;
            end
            if (busy && !busy_q) grant_log.push_back(grant_id);
            while (pend_cmd.size() > 0 && pend_data.size() > 0) begin
                c = pend_cmd.pop_front();
                d = pend_data.pop_front();
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected: got addr %h data %h, expected nothing", c[CW-1 -: AW], d[63:0]);
                end else begin
                    e = exp_q.pop_front();
                    if ({c, d} !== e) begin
                        n_fail++;
                        $display("FAIL sb_beat: got addr %h mask %h acc %b data %h, expected addr %h mask %h acc %b data %h",
                                 c[CW-1 -: AW], c[NB:1], c[0], d, e[W-1 -: AW], e[BW+NB -: NB], e[BW], e[BW-1:0]);
                    end
                end
            end
        end
        busy_q = busy;
    end

    // driver: one full transaction from requester i, each handshake retired independently
    task automatic send(input int i, input logic [AW-1:0] a, input logic [NB-1:0] m,
                        input logic acc, input logic [BW-1:0] d, output bit ok);
        bit c_done = 1'b0;
        bit d_done = 1'b0;
        int cyc = 0;
        bus.req_wr_addr[i*AW +: AW] = a;
        bus.req_wr_mask[i*NB +: NB] = m;
        bus.req_accum_en[i]         = acc;
        bus.req_wdata[i*BW +: BW]   = d;
        bus.req_wr_valid[i]         = 1'b1;
        bus.req_wvalid[i]           = 1'b1;
        while (!(c_done && d_done) && cyc < 60) begin
            @(negedge clk);
            if (bus.req_wr_valid[i] && bus.req_wr_ready[i]) c_done = 1'b1;
            if (bus.req_wvalid[i] && bus.req_wready[i]) d_done = 1'b1;
            @(posedge clk); #1;
            if (c_done) bus.req_wr_valid[i] = 1'b0;
            if (d_done) bus.req_wvalid[i] = 1'b0;
            cyc++;
        end
        bus.req_wr_valid[i] = 1'b0;
        bus.req_wvalid[i]   = 1'b0;
        ok = c_done && d_done;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++; if (grant_id !== 1'b0) begin n_fail++; $display("FAIL reset_grant: got %0d expected 0", grant_id); end
        n_cmp++; if ({bus.zone_wr_valid, bus.zone_wvalid} !== 2'b00) begin
            n_fail++; $display("FAIL reset_zone_valid: got %b expected 00", {bus.zone_wr_valid, bus.zone_wvalid}); end
        n_cmp++; if ({bus.req_wr_ready, bus.req_wready} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_ready: got %b expected 0000", {bus.req_wr_ready, bus.req_wready}); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_single();
        exp_q.push_back({AW'(12'h010), 4'hF, 1'b0, pattern(0, 7)});
        bus.zone_wr_ready = 1'b1;
        bus.zone_wready   = 1'b1;
        bus.req_wr_addr[0 +: AW] = AW'(12'h010);
        bus.req_wr_mask[0 +: NB] = 4'hF;
        bus.req_accum_en[0]      = 1'b0;
        bus.req_wdata[0 +: BW]   = pattern(0, 7);
        bus.req_wr_valid[0]      = 1'b1;
        bus.req_wvalid[0]        = 1'b1;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_arb_latency: busy got %b expected 0", busy); end
        n_cmp++; if (bus.req_wr_ready !== 2'b00) begin n_fail++; $display("FAIL single_idle_ready: got %b expected 00", bus.req_wr_ready); end
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b expected 1", busy); end
        n_cmp++; if ({bus.zone_wr_valid, bus.zone_wvalid} !== 2'b11) begin
            n_fail++; $display("FAIL single_zone_valid: got %b expected 11", {bus.zone_wr_valid, bus.zone_wvalid}); end
        n_cmp++; if ({bus.req_wr_ready, bus.req_wready} !== 4'b0101) begin
            n_fail++; $display("FAIL single_ready: got %b expected 0101", {bus.req_wr_ready, bus.req_wready}); end
        n_cmp++; if (bus.zone_wr_addr !== AW'(12'h010)) begin n_fail++; $display("FAIL single_addr: got %h expected 010", bus.zone_wr_addr); end
        @(posedge clk); #1;
        bus.req_wr_valid[0] = 1'b0;
        bus.req_wvalid[0]   = 1'b0;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_release: busy got %b expected 0", busy); end
    endtask

    task automatic test_data_stall();
        int c0, d0;
        c0 = cmd_beats;
        d0 = data_beats;
        exp_q.push_back({AW'(12'h055), 4'h3, 1'b1, pattern(1, 5)});
        bus.zone_wr_ready = 1'b1;
        bus.zone_wready   = 1'b0;
        bus.req_wr_addr[AW +: AW] = AW'(12'h055);
        bus.req_wr_mask[NB +: NB] = 4'h3;
        bus.req_accum_en[1]       = 1'b1;
        bus.req_wdata[BW +: BW]   = pattern(1, 5);
        bus.req_wr_valid[1]       = 1'b1;
        bus.req_wvalid[1]         = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++; if (grant_id !== 1'b1) begin n_fail++; $display("FAIL stall_grant: got %0d expected 1", grant_id); end
        n_cmp++; if ({bus.req_wr_ready, bus.req_wready} !== 4'b1000) begin
            n_fail++; $display("FAIL stall_first_ready: got %b expected 1000", {bus.req_wr_ready, bus.req_wready}); end
        @(posedge clk); #1;
        bus.req_wr_valid[1] = 1'b0;
        @(negedge clk);
        n_cmp++; if ({bus.zone_wr_valid, bus.req_wr_ready, bus.req_wready} !== 5'b00000) begin
            n_fail++; $display("FAIL stall_cmd_done: got %b expected 00000", {bus.zone_wr_valid, bus.req_wr_ready, bus.req_wready}); end
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL stall_hold: busy got %b expected 1", busy); end
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++; if (bus.req_wready !== 2'b00) begin n_fail++; $display("FAIL stall_wready_low: got %b expected 00", bus.req_wready); end
        @(posedge clk); #1;
        bus.zone_wready = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.req_wready !== 2'b10) begin n_fail++; $display("FAIL stall_wready_rise: got %b expected 10", bus.req_wready); end
        @(posedge clk); #1;
        bus.req_wvalid[1] = 1'b0;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stall_release: busy got %b expected 0", busy); end
        n_cmp++; if ((cmd_beats - c0) != 1 || (data_beats - d0) != 1) begin
            n_fail++; $display("FAIL stall_beats: got cmd %0d data %0d expected 1 1", cmd_beats - c0, data_beats - d0); end
    endtask

    task automatic test_contention();
        logic [GW-1:0] exp_g[$];
        logic [GW-1:0] g;
        grant_log.delete();
        bus.zone_wr_ready = 1'b1;
        bus.zone_wready   = 1'b1;
`ifdef ACCUM_ZONE_ARB_RR_EN
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < 2; i++) begin
                exp_q.push_back({addr_of(i, k), 4'hF, 1'b1, pattern(i, k)});
                exp_g.push_back(GW'(i));
            end
`else
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 4; k++) begin
                exp_q.push_back({addr_of(i, k), 4'hF, 1'b1, pattern(i, k)});
                exp_g.push_back(GW'(i));
            end
`endif
        fork
            begin
                bit ok0;
                for (int k = 0; k < 4; k++) begin
                    send(0, addr_of(0, k), 4'hF, 1'b1, pattern(0, k), ok0);
                    n_cmp++; if (!ok0) begin n_fail++; $display("FAIL contend_timeout_r0: txn %0d got stuck expected done", k); end
                end
            end
            begin
                bit ok1;
                for (int k = 0; k < 4; k++) begin
                    send(1, addr_of(1, k), 4'hF, 1'b1, pattern(1, k), ok1);
                    n_cmp++; if (!ok1) begin n_fail++; $display("FAIL contend_timeout_r1: txn %0d got stuck expected done", k); end
                end
            end
        join
        @(negedge clk);
        n_cmp++; if (grant_log.size() != 8) begin n_fail++; $display("FAIL contend_grant_count: got %0d expected 8", grant_log.size()); end
        for (int j = 0; j < 8 && grant_log.size() > 0; j++) begin
            g = grant_log.pop_front();
            n_cmp++; if (g !== exp_g[j]) begin n_fail++; $display("FAIL contend_order: slot %0d got %0d expected %0d", j, g, exp_g[j]); end
        end
    endtask

    task automatic test_reset_in_lock();
        bus.zone_wr_ready = 1'b1;
        bus.zone_wready   = 1'b0;
        bus.req_wr_addr[AW +: AW] = AW'(12'h3A5);
        bus.req_wr_mask[NB +: NB] = 4'h9;
        bus.req_wdata[BW +: BW]   = pattern(1, 99);
        bus.req_wr_valid[1]       = 1'b1;
        bus.req_wvalid[1]         = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++; if ({busy, grant_id} !== 2'b11) begin n_fail++; $display("FAIL rstlock_locked: got %b expected 11", {busy, grant_id}); end
        @(posedge clk); #1;
        bus.req_wr_valid[1] = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if ({bus.zone_wr_valid, bus.zone_wvalid, bus.req_wr_ready, bus.req_wready} !== 6'b000000) begin
            n_fail++; $display("FAIL rstlock_gated: got %b expected 000000",
                               {bus.zone_wr_valid, bus.zone_wvalid, bus.req_wr_ready, bus.req_wready}); end
        @(posedge clk); #1;
        rst = 1'b0;
        bus.req_wvalid[1] = 1'b0;
        bus.zone_wready   = 1'b1;
        @(negedge clk);
        n_cmp++; if ({busy, grant_id, bus.zone_wvalid, bus.zone_wr_valid} !== 4'b0000) begin
            n_fail++; $display("FAIL rstlock_idle: got %b expected 0000", {busy, grant_id, bus.zone_wvalid, bus.zone_wr_valid}); end
        n_cmp++; if (pend_cmd.size() != 1 || pend_data.size() != 0) begin
            n_fail++; $display("FAIL rstlock_partial: got cmd %0d data %0d expected 1 0", pend_cmd.size(), pend_data.size()); end
        pend_cmd.delete();
        pend_data.delete();
    endtask

    initial begin
        rst               = 1'b1;
        bus.req_wr_valid  = '0;
        bus.req_wr_addr   = '0;
        bus.req_wr_mask   = '0;
        bus.req_accum_en  = '0;
        bus.req_wvalid    = '0;
        bus.req_wdata     = '0;
        bus.zone_wr_ready = 1'b1;
        bus.zone_wready   = 1'b1;
        test_reset();
        test_single();
        test_data_stall();
        test_contention();
        test_reset_in_lock();
        repeat (2) @(negedge clk);
        n_cmp++; if (exp_q.size() != 0 || pend_cmd.size() != 0 || pend_data.size() != 0) begin
            n_fail++; $display("FAIL final_drain: got exp %0d cmd %0d data %0d left expected 0 0 0",
                               exp_q.size(), pend_cmd.size(), pend_data.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
